// File: rtl/asip_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | asip_ctrl_pkg                                                            |
// | Shared types and encodings for the RSA-ASIP pipeline control unit.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package asip_ctrl_pkg;

  localparam int C_RW = 5;

  typedef enum logic [2:0] {
    OP_ALU_R  = 3'b000,
    OP_ALU_I  = 3'b001,
    OP_LOAD   = 3'b010,
    OP_STORE  = 3'b011,
    OP_BRANCH = 3'b100,
    OP_HALT   = 3'b101,
    OP_NOP6   = 3'b110,
    OP_NOP7   = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    BR_BEQ  = 2'b00,
    BR_BNE  = 2'b01,
    BR_JMP  = 2'b10,
    BR_NONE = 2'b11
  } branch_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_BRANCH = 2'b01,
    EXT_ZERO   = 2'b10,
    EXT_UNUSED = 2'b11
  } ext_sel_t;

  typedef struct packed {
    logic            valid;
    logic            wr_en;
    logic [C_RW-1:0] rw;
    branch_t         br_type;
  } shadow_t;

  localparam shadow_t C_SHADOW_BUBBLE = '{valid: 1'b0, wr_en: 1'b0, rw: '0, br_type: BR_NONE};

  function automatic logic br_taken(input branch_t br, input logic z);
    case (br)
      BR_BEQ:  return z;
      BR_BNE:  return !z;
      BR_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_detect                                                            |
// | RAW check of the ID-stage sources against the in-flight writers.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hazard_detect
  import asip_ctrl_pkg::*;
#(
  parameter int RW     = C_RW,
  parameter int NSTAGE = 3
) (
  input  logic [RW-1:0]             ra_id,
  input  logic [RW-1:0]             rb_id,
  input  logic                      use_ra,
  input  logic                      use_rb,
  input  logic [NSTAGE-1:0]         wr_valid,
  input  logic [NSTAGE-1:0][RW-1:0] wr_rw,
  output logic                      hazard
);

  logic              w_ra_live;
  logic              w_rb_live;
  logic [NSTAGE-1:0] w_hit;

  // r0 reads as constant zero, so it can never depend on a writer
  assign w_ra_live = use_ra && (ra_id != '0);
  assign w_rb_live = use_rb && (rb_id != '0);

  generate
    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
      assign w_hit[g] = wr_valid[g] &&
                        ((w_ra_live && (ra_id == wr_rw[g])) ||
                         (w_rb_live && (rb_id == wr_rw[g])));
    end
  endgenerate

  assign hazard = |w_hit;

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_unit                                                             |
// | ID-stage decode, shadow writer pipe, RAW stall, branch flush and halt.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module control_unit
  import asip_ctrl_pkg::*;
#(
  parameter int RW    = C_RW,
  parameter int DRAIN = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run_en,
  input  logic [2:0]    opcode,
  input  logic [1:0]    func,
  input  logic [RW-1:0] ra_id,
  input  logic [RW-1:0] rb_id,
  input  logic [RW-1:0] rw_id,
  input  logic          z_ex,
  output logic [1:0]    branch,
  output logic [1:0]    ext_selector,
  output logic          rb_selector,
  output logic          wr_en_id,
  output logic          opb_sel_id,
  output logic          alu_func_id,
  output logic          wd_sel_id,
  output logic          wm_en_id,
  output logic          stall,
  output logic          flush,
  output logic          halted
);

  localparam int C_CNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_nxt;
  shadow_t              r_ex;
  shadow_t              r_mem;
  shadow_t              r_wb;
  shadow_t              w_id_entry;
  shadow_t              w_ex_nxt;
  logic                 r_flush_q;

  opcode_t              w_op;
  logic                 w_dec_wr;
  logic                 w_dec_opb;
  logic                 w_dec_alu;
  logic                 w_dec_wd;
  logic                 w_dec_wm;
  logic                 w_dec_rbs;
  ext_sel_t             w_dec_ext;
  branch_t              w_dec_br;
  logic                 w_use_ra;
  logic                 w_use_rb;
  logic                 w_is_halt;

  logic                 w_run;
  logic                 w_taken;
  logic                 w_squash;
  logic                 w_hazard;
  logic                 w_issue;
  logic                 w_unused;

  assign w_op = opcode_t'(opcode);

  always_comb begin
    w_dec_wr  = 1'b0;
    w_dec_opb = 1'b0;
    w_dec_alu = 1'b0;
    w_dec_wd  = 1'b0;
    w_dec_wm  = 1'b0;
    w_dec_rbs = 1'b0;
    w_dec_ext = EXT_SIGN;
    w_dec_br  = BR_NONE;
    w_use_ra  = 1'b0;
    w_use_rb  = 1'b0;
    w_is_halt = 1'b0;
    case (w_op)
      OP_ALU_R: begin
        w_dec_wr  = 1'b1;
        w_dec_alu = func[0];
        w_use_ra  = 1'b1;
        w_use_rb  = 1'b1;
      end
      OP_ALU_I: begin
        w_dec_wr  = 1'b1;
        w_dec_opb = 1'b1;
        w_dec_alu = func[0];
        w_use_ra  = 1'b1;
      end
      OP_LOAD: begin
        w_dec_wr  = 1'b1;
        w_dec_opb = 1'b1;
        w_dec_wd  = 1'b1;
        w_use_ra  = 1'b1;
      end
      OP_STORE: begin
        w_dec_wm  = 1'b1;
        w_dec_rbs = 1'b1;
        w_dec_opb = 1'b1;
        w_use_ra  = 1'b1;
        w_use_rb  = 1'b1;
      end
      OP_BRANCH: begin
        if (branch_t'(func) != BR_NONE) begin
          w_dec_rbs = 1'b1;
          w_dec_alu = 1'b1;
          w_dec_ext = EXT_BRANCH;
          w_dec_br  = branch_t'(func);
          w_use_ra  = (branch_t'(func) != BR_JMP);
          w_use_rb  = (branch_t'(func) != BR_JMP);
        end
      end
      OP_HALT: w_is_halt = 1'b1;
      default: ;
    endcase
  end

  hazard_detect #(
    .RW     (RW),
    .NSTAGE (3)
  ) u_hazard (
    .ra_id    (ra_id),
    .rb_id    (rb_id),
    .use_ra   (w_use_ra),
    .use_rb   (w_use_rb),
    .wr_valid ({r_wb.valid & r_wb.wr_en, r_mem.valid & r_mem.wr_en, r_ex.valid & r_ex.wr_en}),
    .wr_rw    ({r_wb.rw, r_mem.rw, r_ex.rw}),
    .hazard   (w_hazard)
  );

  // The taken branch's flush cycle and the following one are both wrong-path slots
  assign w_run    = (r_state == ST_RUN);
  assign w_taken  = r_ex.valid && br_taken(r_ex.br_type, z_ex);
  assign w_squash = w_taken || r_flush_q;
  assign w_issue  = w_run && !w_squash && !w_hazard;

  assign stall  = !w_run || (w_hazard && !w_squash);
  assign flush  = w_taken;
  assign halted = (r_state == ST_HALTED);
  assign branch = r_ex.br_type;

  assign wr_en_id     = w_dec_wr  && w_issue;
  assign opb_sel_id   = w_dec_opb && w_issue;
  assign alu_func_id  = w_dec_alu && w_issue;
  assign wd_sel_id    = w_dec_wd  && w_issue;
  assign wm_en_id     = w_dec_wm  && w_issue;
  assign ext_selector = w_issue ? w_dec_ext : EXT_SIGN;
  // rb_selector feeds the rb_id mux that the hazard check reads, so it must not depend on stall
  assign rb_selector  = w_dec_rbs && w_run && !w_squash;

  assign w_id_entry = '{valid: 1'b1, wr_en: w_dec_wr, rw: rw_id, br_type: w_dec_br};
  assign w_ex_nxt   = w_issue ? w_id_entry : C_SHADOW_BUBBLE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (run_en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!run_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_issue && w_is_halt) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = C_CNT_W'(DRAIN - 1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == '0) w_state_nxt = ST_HALTED;
        else             w_cnt_nxt   = r_cnt - C_CNT_W'(1);
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ex      <= C_SHADOW_BUBBLE;
      r_mem     <= C_SHADOW_BUBBLE;
      r_wb      <= C_SHADOW_BUBBLE;
      r_flush_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ex      <= w_ex_nxt;
      r_mem     <= r_ex;
      r_wb      <= r_mem;
      r_flush_q <= w_taken;
    end
  end

  assign w_unused = ^{r_mem.br_type, r_wb.br_type};

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_control_unit                                                          |
// | Table-driven and sequence checks of the pipeline control unit.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_control_unit;

  typedef struct {
    logic       run;
    logic [2:0] op;
    logic [1:0] fn;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rw;
    logic       z;
    logic [5:0] stb;   // {wr_en, opb_sel, alu_func, wd_sel, wm_en, rb_selector}
    logic [1:0] ext;
    logic [1:0] br;
    logic       st;
    logic       fl;
    logic       hl;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       run_en;
  logic [2:0] opcode;
  logic [1:0] func;
  logic [4:0] ra_id;
  logic [4:0] rb_id;
  logic [4:0] rw_id;
  logic       z_ex;
  logic [1:0] branch;
  logic [1:0] ext_selector;
  logic       rb_selector;
  logic       wr_en_id;
  logic       opb_sel_id;
  logic       alu_func_id;
  logic       wd_sel_id;
  logic       wm_en_id;
  logic       stall;
  logic       flush;
  logic       halted;

  int   checks   = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t tbl[11];
  vec_t rst_exp;

  control_unit #(.RW(5), .DRAIN(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .run_en       (run_en),
    .opcode       (opcode),
    .func         (func),
    .ra_id        (ra_id),
    .rb_id        (rb_id),
    .rw_id        (rw_id),
    .z_ex         (z_ex),
    .branch       (branch),
    .ext_selector (ext_selector),
    .rb_selector  (rb_selector),
    .wr_en_id     (wr_en_id),
    .opb_sel_id   (opb_sel_id),
    .alu_func_id  (alu_func_id),
    .wd_sel_id    (wd_sel_id),
    .wm_en_id     (wm_en_id),
    .stall        (stall),
    .flush        (flush),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  function automatic vec_t mkv(input logic run, input logic [2:0] op, input logic [1:0] fn,
                               input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                               input logic z, input logic [5:0] stb, input logic [1:0] ext,
                               input logic [1:0] br, input logic st, input logic fl, input logic hl);
    vec_t v;
    v.run = run; v.op = op; v.fn = fn; v.ra = ra; v.rb = rb; v.rw = rw; v.z = z;
    v.stb = stb; v.ext = ext; v.br = br; v.st = st; v.fl = fl; v.hl = hl;
    return v;
  endfunction

  task automatic chk(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  task automatic compare(input string name, input vec_t e);
    chk(name, "strobes", {2'b00, wr_en_id, opb_sel_id, alu_func_id, wd_sel_id, wm_en_id, rb_selector},
        {2'b00, e.stb});
    chk(name, "ext",    {6'd0, ext_selector}, {6'd0, e.ext});
    chk(name, "branch", {6'd0, branch},       {6'd0, e.br});
    chk(name, "stall",  {7'd0, stall},        {7'd0, e.st});
    chk(name, "flush",  {7'd0, flush},        {7'd0, e.fl});
    chk(name, "halted", {7'd0, halted},       {7'd0, e.hl});
  endtask

  task automatic apply(input string name, input vec_t v);
    vec_t e;
    @(posedge clock);
    #1;
    run_en = v.run; opcode = v.op; func = v.fn;
    ra_id = v.ra; rb_id = v.rb; rw_id = v.rw; z_ex = v.z;
    sb.push_back(v);
    @(negedge clock);
    if (sb.size() == 0) begin
      chk(name, "scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      compare(name, e);
    end
  endtask

  // Called at a falling edge: reset is asserted mid-cycle and released before the next rise
  task automatic async_reset(input string name, input logic run_after);
    #2 reset = 1'b0;
    #1 compare(name, rst_exp);
    opcode = 3'b110; func = 2'b00; ra_id = '0; rb_id = '0; rw_id = '0; z_ex = 1'b0;
    run_en = run_after;
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_exp = mkv(1, 3'b110, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b00, 2'b11, 1, 0, 0);
    tbl[0]  = mkv(1, 3'b000, 2'b01, 0, 0, 0, 0, 6'b101000, 2'b00, 2'b11, 0, 0, 0);
    tbl[1]  = mkv(1, 3'b000, 2'b00, 0, 0, 0, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0);
    tbl[2]  = mkv(1, 3'b001, 2'b01, 0, 0, 0, 0, 6'b111000, 2'b00, 2'b11, 0, 0, 0);
    tbl[3]  = mkv(1, 3'b010, 2'b11, 0, 0, 0, 0, 6'b110100, 2'b00, 2'b11, 0, 0, 0);
    tbl[4]  = mkv(1, 3'b011, 2'b00, 0, 0, 0, 0, 6'b010011, 2'b00, 2'b11, 0, 0, 0);
    tbl[5]  = mkv(1, 3'b100, 2'b00, 0, 0, 0, 0, 6'b001001, 2'b01, 2'b11, 0, 0, 0);
    tbl[6]  = mkv(1, 3'b110, 2'b00, 0, 0, 0, 0, 6'b000000, 2'b00, 2'b00, 0, 0, 0);
    tbl[7]  = mkv(1, 3'b100, 2'b01, 0, 0, 0, 0, 6'b001001, 2'b01, 2'b11, 0, 0, 0);
    tbl[8]  = mkv(1, 3'b111, 2'b00, 0, 0, 0, 1, 6'b000000, 2'b00, 2'b01, 0, 0, 0);
    tbl[9]  = mkv(1, 3'b100, 2'b11, 0, 0, 0, 0, 6'b000000, 2'b00, 2'b11, 0, 0, 0);
    tbl[10] = mkv(1, 3'b000, 2'b00, 0, 0, 0, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0);

    reset = 1'b0; run_en = 1'b1; opcode = 3'b110; func = 2'b00;
    ra_id = '0; rb_id = '0; rw_id = '0; z_ex = 1'b0;
    #12 compare("reset_hold", rst_exp);
    #1 reset = 1'b1;
    @(negedge clock);
    compare("run_after_release", mkv(1, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));

    for (int i = 0; i < 11; i++) apply($sformatf("dec%0d", i), tbl[i]);

    // RAW on ra from an ALU writer: three stall slots, issue on the fourth
    apply("haz_w3", mkv(1, 3'b000, 0, 1, 2, 3, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      apply($sformatf("haz_stall%0d", i), mkv(1, 3'b000, 0, 3, 1, 4, 0, 6'b0, 2'b00, 2'b11, 1, 0, 0));
    apply("haz_issue",  mkv(1, 3'b000, 0, 3, 1, 4, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));
    apply("haz_alui_rb", mkv(1, 3'b001, 0, 0, 4, 5, 0, 6'b110000, 2'b00, 2'b11, 0, 0, 0));
    apply("haz_r0_w",   mkv(1, 3'b000, 0, 0, 0, 0, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));
    apply("haz_r0_rd",  mkv(1, 3'b000, 0, 0, 0, 6, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));
    apply("haz_rb_wb",  mkv(1, 3'b000, 0, 0, 5, 0, 0, 6'b0, 2'b00, 2'b11, 1, 0, 0));
    apply("haz_rb_rel", mkv(1, 3'b000, 0, 0, 5, 0, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));

    // Taken BEQ with a coincident hazard: flush wins, two squashed slots
    apply("brs_w7",    mkv(1, 3'b000, 0, 0, 0, 7, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));
    apply("brs_beq",   mkv(1, 3'b100, 0, 0, 0, 0, 0, 6'b001001, 2'b01, 2'b11, 0, 0, 0));
    apply("brs_taken", mkv(1, 3'b000, 0, 7, 0, 0, 1, 6'b0, 2'b00, 2'b00, 0, 1, 0));
    apply("brs_sq",    mkv(1, 3'b000, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));
    apply("brs_after", mkv(1, 3'b000, 0, 7, 0, 0, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));

    // JMP ignores sources, and a HALT in its shadow must be dropped
    apply("jmp_w5",     mkv(1, 3'b000, 0, 0, 0, 5, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));
    apply("jmp",        mkv(1, 3'b100, 2'b10, 5, 5, 0, 0, 6'b001001, 2'b01, 2'b11, 0, 0, 0));
    apply("jmp_halt",   mkv(1, 3'b101, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b10, 0, 1, 0));
    apply("jmp_halt2",  mkv(1, 3'b101, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));
    apply("jmp_nohalt0", mkv(1, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));
    apply("jmp_nohalt1", mkv(1, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));

    // HALT: three drain cycles, then halted holds regardless of run_en
    apply("halt_id", mkv(1, 3'b101, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      apply($sformatf("halt_drain%0d", i), mkv(1, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 1, 0, 0));
    apply("halted",      mkv(1, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 1, 0, 1));
    apply("halted_hold", mkv(0, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 1, 0, 1));
    apply("halted_hold2", mkv(0, 3'b000, 0, 0, 0, 1, 0, 6'b0, 2'b00, 2'b11, 1, 0, 1));
    async_reset("rst_halted", 1'b1);
    apply("post_rst", mkv(1, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));

    // Reset in the middle of DRAIN cancels the pending halt
    apply("halt_id2", mkv(1, 3'b101, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));
    apply("drain_a",  mkv(1, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 1, 0, 0));
    async_reset("rst_drain", 1'b1);
    for (int i = 0; i < 4; i++)
      apply($sformatf("post_drain%0d", i), mkv(1, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));

    // Reset during a hazard stall with a branch in EX
    apply("ms_w3",    mkv(1, 3'b000, 0, 0, 0, 3, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));
    apply("ms_beq",   mkv(1, 3'b100, 0, 0, 0, 0, 0, 6'b001001, 2'b01, 2'b11, 0, 0, 0));
    apply("ms_stall", mkv(1, 3'b000, 0, 3, 0, 0, 0, 6'b0, 2'b00, 2'b00, 1, 0, 0));
    async_reset("rst_stall", 1'b0);
    apply("idle_hold", mkv(0, 3'b000, 0, 3, 0, 0, 0, 6'b0, 2'b00, 2'b11, 1, 0, 0));
    apply("idle_go",   mkv(1, 3'b000, 0, 3, 0, 0, 0, 6'b0, 2'b00, 2'b11, 1, 0, 0));
    apply("idle_run",  mkv(1, 3'b000, 0, 3, 0, 0, 0, 6'b100000, 2'b00, 2'b11, 0, 0, 0));
    apply("run_stop",  mkv(0, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 0, 0, 0));
    apply("stopped",   mkv(0, 3'b110, 0, 0, 0, 0, 0, 6'b0, 2'b00, 2'b11, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
